// File: rtl/vga_axil_native_bridge.sv
// AXI4-Lite slave to native single-cycle register/memory port bridge with independent read/write FSMs.
// Optional address range check with SLVERR response is enabled by defining VGA_AXIL_SLVERR_EN.
module vga_axil_native_bridge #(
  parameter int unsigned AXIL_ADDR_W   = 32,
  parameter int unsigned AXIL_DATA_W   = 32,
  parameter int unsigned NATIVE_ADDR_W = 10,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned NUM_WORDS     = 2 ** NATIVE_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXIL_ADDR_W-1:0]     awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [AXIL_DATA_W-1:0]     wdata,
  input  logic [AXIL_DATA_W/8-1:0]   wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  input  logic [AXIL_ADDR_W-1:0]     araddr,
  input  logic                       arvalid,
  output logic                       arready,
  output logic [AXIL_DATA_W-1:0]     rdata,
  output logic [1:0]                 rresp,
  output logic                       rvalid,
  input  logic                       rready,
  output logic                       write_en_o,
  output logic [NATIVE_ADDR_W-1:0]   addr_write_o,
  output logic [AXIL_DATA_W-1:0]     data_o,
  output logic [AXIL_DATA_W/8-1:0]   strb_o,
  output logic                       read_en_o,
  output logic [NATIVE_ADDR_W-1:0]   addr_read_o,
  input  logic [AXIL_DATA_W-1:0]     data_i
);

  localparam int unsigned STRB_W   = AXIL_DATA_W / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Reject parameter sets the datapath cannot represent.
  if (AXIL_DATA_W < 8 || (AXIL_DATA_W & (AXIL_DATA_W - 1)) != 0) begin : g_bad_data_w
    $error("AXIL_DATA_W must be a power of two >= 8");
  end
  if (READ_LATENCY < 1) begin : g_bad_latency
    $error("READ_LATENCY must be >= 1");
  end
  if (NUM_WORDS < 1) begin : g_bad_num_words
    $error("NUM_WORDS must be >= 1");
  end

  typedef enum logic [2:0] {
    W_IDLE, W_HAVE_AW, W_HAVE_W, W_EXEC, W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE, R_ISSUE, R_WAIT, R_RESP
  } r_state_t;

  w_state_t w_state_q, w_state_n;
  r_state_t r_state_q, r_state_n;

  logic                     aw_hs_c, w_hs_c, ar_hs_c;
  logic                     aw_err_c, ar_err_c;
  logic                     w_err_q, r_err_q;
  logic                     w_err_n_c, r_err_n_c;
  logic [NATIVE_ADDR_W-1:0] aw_word_c, ar_word_c;
  logic [CNT_W-1:0]         rd_cnt_q;
  logic                     unused_addr;

  assign aw_hs_c   = awvalid & awready;
  assign w_hs_c    = wvalid & wready;
  assign ar_hs_c   = arvalid & arready;
  assign aw_word_c = awaddr[ADDR_LSB +: NATIVE_ADDR_W];
  assign ar_word_c = araddr[ADDR_LSB +: NATIVE_ADDR_W];

`ifdef VGA_AXIL_SLVERR_EN
  // Full byte address is range-checked so high bits beyond the native port still fault.
  function automatic logic range_err(input logic [AXIL_ADDR_W-1:0] a);
    return (64'(a) >> ADDR_LSB) >= 64'(NUM_WORDS);
  endfunction

  assign aw_err_c = range_err(awaddr);
  assign ar_err_c = range_err(araddr);
`else
  assign aw_err_c = 1'b0;
  assign ar_err_c = 1'b0;
`endif
  assign unused_addr = ^{awaddr, araddr};

  // Error flag as it will stand after this edge; gates the native strobes.
  assign w_err_n_c = aw_hs_c ? aw_err_c : w_err_q;
  assign r_err_n_c = ar_hs_c ? ar_err_c : r_err_q;

  // Write state register
  always_ff @(posedge clk) begin
    if (rst) w_state_q <= W_IDLE;
    else     w_state_q <= w_state_n;
  end

  // Write next-state: AW and W are accepted in either order
  always_comb begin
    w_state_n = w_state_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_c && w_hs_c) w_state_n = W_EXEC;
        else if (aw_hs_c)      w_state_n = W_HAVE_AW;
        else if (w_hs_c)       w_state_n = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs_c)  w_state_n = W_EXEC;
      W_HAVE_W:  if (aw_hs_c) w_state_n = W_EXEC;
      W_EXEC:                 w_state_n = W_RESP;
      W_RESP:    if (bready)  w_state_n = W_IDLE;
      default:                w_state_n = W_IDLE;
    endcase
  end

  // Write channel registered outputs and capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      awready      <= 1'b0;
      wready       <= 1'b0;
      bvalid       <= 1'b0;
      bresp        <= RESP_OKAY;
      write_en_o   <= 1'b0;
      addr_write_o <= '0;
      data_o       <= '0;
      strb_o       <= '0;
      w_err_q      <= 1'b0;
    end else begin
      awready    <= (w_state_n == W_IDLE) || (w_state_n == W_HAVE_W);
      wready     <= (w_state_n == W_IDLE) || (w_state_n == W_HAVE_AW);
      bvalid     <= (w_state_n == W_RESP);
      write_en_o <= (w_state_n == W_EXEC) && !w_err_n_c;
      if (aw_hs_c) begin
        addr_write_o <= aw_word_c;
        w_err_q      <= aw_err_c;
      end
      if (w_hs_c) begin
        data_o <= wdata;
        strb_o <= wstrb;
      end
      if (w_state_q == W_EXEC) bresp <= w_err_q ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Read state register
  always_ff @(posedge clk) begin
    if (rst) r_state_q <= R_IDLE;
    else     r_state_q <= r_state_n;
  end

  // Read next-state
  always_comb begin
    r_state_n = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs_c)          r_state_n = R_ISSUE;
      R_ISSUE:                       r_state_n = R_WAIT;
      R_WAIT:  if (rd_cnt_q == '0)   r_state_n = R_RESP;
      R_RESP:  if (rready)           r_state_n = R_IDLE;
      default:                       r_state_n = R_IDLE;
    endcase
  end

  // Read channel registered outputs, latency counter and capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      arready     <= 1'b0;
      rvalid      <= 1'b0;
      rresp       <= RESP_OKAY;
      rdata       <= '0;
      read_en_o   <= 1'b0;
      addr_read_o <= '0;
      r_err_q     <= 1'b0;
      rd_cnt_q    <= '0;
    end else begin
      arready   <= (r_state_n == R_IDLE);
      rvalid    <= (r_state_n == R_RESP);
      read_en_o <= (r_state_n == R_ISSUE) && !r_err_n_c;
      if (ar_hs_c) begin
        addr_read_o <= ar_word_c;
        r_err_q     <= ar_err_c;
      end
      if (r_state_q == R_ISSUE) begin
        rd_cnt_q <= CNT_W'(READ_LATENCY - 1);
      end else if (r_state_q == R_WAIT && rd_cnt_q != '0) begin
        rd_cnt_q <= rd_cnt_q - CNT_W'(1);
      end
      if (r_state_q == R_WAIT && rd_cnt_q == '0) begin
        rdata <= r_err_q ? '0 : data_i;
        rresp <= r_err_q ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_vga_axil_native_bridge.sv
// Directed self-checking bench for vga_axil_native_bridge (READ_LATENCY=3, NUM_WORDS=16).
module tb_vga_axil_native_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        write_en_o;
  logic [9:0]  addr_write_o;
  logic [31:0] data_o;
  logic [3:0]  strb_o;
  logic        read_en_o;
  logic [9:0]  addr_read_o;
  logic [31:0] data_i;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef VGA_AXIL_SLVERR_EN
  localparam logic       OOR_STROBE = 1'b0;
  localparam logic [1:0] OOR_RESP   = 2'b10;
`else
  localparam logic       OOR_STROBE = 1'b1;
  localparam logic [1:0] OOR_RESP   = 2'b00;
`endif

  vga_axil_native_bridge #(
    .AXIL_ADDR_W(32), .AXIL_DATA_W(32), .NATIVE_ADDR_W(10),
    .READ_LATENCY(3), .NUM_WORDS(16)
  ) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .write_en_o(write_en_o), .addr_write_o(addr_write_o), .data_o(data_o), .strb_o(strb_o),
    .read_en_o(read_en_o), .addr_read_o(addr_read_o), .data_i(data_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1; data_i = '0;
    repeat (3) step();
    tests_run++;
    if ({awready, wready, arready, bvalid, rvalid, write_en_o, read_en_o} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {awready, wready, arready, bvalid, rvalid, write_en_o, read_en_o});
    end
    tests_run++;
    if ({addr_write_o, data_o, strb_o, addr_read_o, rdata, bresp, rresp} !== 92'b0) begin
      tests_failed++;
      $display("FAIL reset_data got=%h exp=0",
               {addr_write_o, data_o, strb_o, addr_read_o, rdata, bresp, rresp});
    end
    rst = 1'b0;
    step();
    tests_run++;
    if ({awready, wready, arready} !== 3'b111) begin
      tests_failed++;
      $display("FAIL reset_release_ready got=%b exp=111", {awready, wready, arready});
    end
  endtask

  task automatic test_write_same_cycle();
    awaddr = 32'h0000_0010; awvalid = 1'b1;
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    tests_run++;
    if ({write_en_o, addr_write_o, data_o, strb_o, bvalid, awready, wready} !==
        {1'b1, 10'd4, 32'hDEAD_BEEF, 4'hF, 3'b000}) begin
      tests_failed++;
      $display("FAIL wr_same_exec got=%h exp=%h",
               {write_en_o, addr_write_o, data_o, strb_o, bvalid, awready, wready},
               {1'b1, 10'd4, 32'hDEAD_BEEF, 4'hF, 3'b000});
    end
    step();
    tests_run++;
    if ({write_en_o, bvalid, bresp} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL wr_same_resp got=%b exp=0100", {write_en_o, bvalid, bresp});
    end
    step();
    tests_run++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      tests_failed++;
      $display("FAIL wr_same_idle got=%b exp=011", {bvalid, awready, wready});
    end
  endtask

  task automatic test_aw_first();
    awaddr = 32'h0000_001C; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    tests_run++;
    if ({awready, wready, write_en_o} !== 3'b010) begin
      tests_failed++;
      $display("FAIL aw_first_wait got=%b exp=010", {awready, wready, write_en_o});
    end
    step();
    wdata = 32'hA5A5_0F0F; wstrb = 4'hC; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    tests_run++;
    if ({write_en_o, addr_write_o, data_o, strb_o} !== {1'b1, 10'd7, 32'hA5A5_0F0F, 4'hC}) begin
      tests_failed++;
      $display("FAIL aw_first_exec got=%h exp=%h", {write_en_o, addr_write_o, data_o, strb_o},
               {1'b1, 10'd7, 32'hA5A5_0F0F, 4'hC});
    end
    step();
    step();
  endtask

  task automatic test_w_first();
    wdata = 32'h1234_5678; wstrb = 4'h3; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({awready, wready, write_en_o} !== 3'b100) begin
        tests_failed++;
        $display("FAIL w_first_wait[%0d] got=%b exp=100", i, {awready, wready, write_en_o});
      end
      if (i < 2) step();
    end
    awaddr = 32'h0000_0008; awvalid = 1'b1;
    step();
    awvalid = 1'b0; bready = 1'b0;
    tests_run++;
    if ({write_en_o, addr_write_o, data_o, strb_o} !== {1'b1, 10'd2, 32'h1234_5678, 4'h3}) begin
      tests_failed++;
      $display("FAIL w_first_exec got=%h exp=%h", {write_en_o, addr_write_o, data_o, strb_o},
               {1'b1, 10'd2, 32'h1234_5678, 4'h3});
    end
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if ({write_en_o, bvalid, bresp, data_o} !== {1'b0, 1'b1, 2'b00, 32'h1234_5678}) begin
        tests_failed++;
        $display("FAIL w_first_bhold[%0d] got=%h exp=%h", i, {write_en_o, bvalid, bresp, data_o},
                 {1'b0, 1'b1, 2'b00, 32'h1234_5678});
      end
    end
    bready = 1'b1;
    step();
    tests_run++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      tests_failed++;
      $display("FAIL w_first_done got=%b exp=011", {bvalid, awready, wready});
    end
  endtask

  task automatic test_read_latency();
    data_i = 32'h0BAD_0BAD; rready = 1'b0;
    araddr = 32'h0000_0004; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    tests_run++;
    if ({read_en_o, addr_read_o, arready} !== {1'b1, 10'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL rd_issue got=%h exp=%h", {read_en_o, addr_read_o, arready}, {1'b1, 10'd1, 1'b0});
    end
    for (int t = 2; t <= 4; t++) begin
      step();
      if (t == 4) data_i = 32'hCAFE_0001;
      tests_run++;
      if ({read_en_o, rvalid, arready} !== 3'b000) begin
        tests_failed++;
        $display("FAIL rd_wait[T+%0d] got=%b exp=000", t, {read_en_o, rvalid, arready});
      end
    end
    step();
    data_i = 32'h0BAD_0BAD;
    tests_run++;
    if ({rvalid, rdata, rresp} !== {1'b1, 32'hCAFE_0001, 2'b00}) begin
      tests_failed++;
      $display("FAIL rd_data got=%h exp=%h", {rvalid, rdata, rresp}, {1'b1, 32'hCAFE_0001, 2'b00});
    end
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if ({rvalid, rdata, arready} !== {1'b1, 32'hCAFE_0001, 1'b0}) begin
        tests_failed++;
        $display("FAIL rd_hold[%0d] got=%h exp=%h", i, {rvalid, rdata, arready},
                 {1'b1, 32'hCAFE_0001, 1'b0});
      end
    end
    rready = 1'b1;
    step();
    tests_run++;
    if ({rvalid, arready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL rd_done got=%b exp=01", {rvalid, arready});
    end
  endtask

  task automatic test_concurrent();
    awaddr = 32'h0000_0020; awvalid = 1'b1; wdata = 32'h1111_2222; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 32'h0000_0024; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    data_i = 32'h55AA_1234;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tests_run++;
    if ({write_en_o, addr_write_o, read_en_o, addr_read_o} !== {1'b1, 10'd8, 1'b1, 10'd9}) begin
      tests_failed++;
      $display("FAIL conc_strobes got=%h exp=%h", {write_en_o, addr_write_o, read_en_o, addr_read_o},
               {1'b1, 10'd8, 1'b1, 10'd9});
    end
    step();
    tests_run++;
    if ({bvalid, bresp, read_en_o, rvalid} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL conc_bresp got=%b exp=10000", {bvalid, bresp, read_en_o, rvalid});
    end
    step();
    step();
    tests_run++;
    if ({bvalid, rvalid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL conc_mid got=%b exp=00", {bvalid, rvalid});
    end
    step();
    tests_run++;
    if ({rvalid, rdata, rresp} !== {1'b1, 32'h55AA_1234, 2'b00}) begin
      tests_failed++;
      $display("FAIL conc_rdata got=%h exp=%h", {rvalid, rdata, rresp}, {1'b1, 32'h55AA_1234, 2'b00});
    end
    step();
    tests_run++;
    if (rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL conc_rdone got=%b exp=0", rvalid);
    end
  endtask

  task automatic test_range();
    awaddr = 32'h0000_0050; awvalid = 1'b1; wdata = 32'h7777_0000; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 32'h0000_0050; arvalid = 1'b1; data_i = 32'h9999_8888;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tests_run++;
    if ({write_en_o, read_en_o, addr_write_o, addr_read_o} !== {OOR_STROBE, OOR_STROBE, 10'd20, 10'd20}) begin
      tests_failed++;
      $display("FAIL range_strobes got=%h exp=%h", {write_en_o, read_en_o, addr_write_o, addr_read_o},
               {OOR_STROBE, OOR_STROBE, 10'd20, 10'd20});
    end
    step();
    tests_run++;
    if ({bvalid, bresp} !== {1'b1, OOR_RESP}) begin
      tests_failed++;
      $display("FAIL range_bresp got=%b exp=%b", {bvalid, bresp}, {1'b1, OOR_RESP});
    end
    repeat (3) step();
    tests_run++;
    if ({rvalid, rresp, rdata} !== {1'b1, OOR_RESP, OOR_STROBE ? 32'h9999_8888 : 32'h0}) begin
      tests_failed++;
      $display("FAIL range_rresp got=%h exp=%h", {rvalid, rresp, rdata},
               {1'b1, OOR_RESP, OOR_STROBE ? 32'h9999_8888 : 32'h0});
    end
    step();
  endtask

  task automatic test_reset_mid_read();
    araddr = 32'h0000_0004; arvalid = 1'b1; rready = 1'b1; data_i = 32'hFEED_F00D;
    step();
    arvalid = 1'b0;
    step();
    rst = 1'b1;
    step();
    tests_run++;
    if ({arready, rvalid, read_en_o, rdata} !== 35'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_abort got=%h exp=0", {arready, rvalid, read_en_o, rdata});
    end
    rst = 1'b0;
    step();
    tests_run++;
    if ({arready, rvalid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL rst_mid_release got=%b exp=10", {arready, rvalid});
    end
    for (int i = 0; i < 6; i++) begin
      step();
      tests_run++;
      if ({rvalid, read_en_o} !== 2'b00) begin
        tests_failed++;
        $display("FAIL rst_mid_quiet[%0d] got=%b exp=00", i, {rvalid, read_en_o});
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_aw_first();
    test_w_first();
    test_read_latency();
    test_concurrent();
    test_range();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_axil_native_bridge.md
# vga_axil_native_bridge
Parametrised AXI4-Lite slave to native single-cycle register/memory port bridge; successor of the fixed-width VGA AXI-Lite slave FSM. Read and write channels run independently and concurrently. AW and W may arrive in any order or cycle, WSTRB is forwarded, and native read latency is configurable. Sits between the AXI-Lite interconnect and the VGA register bank or framebuffer.
## Interface
- AXIL_ADDR_W, 32, AXI byte-address width
- AXIL_DATA_W, 32, data width; power of two, ≥ 8
- NATIVE_ADDR_W, 10, native word-address width; native addr = byte addr[NATIVE_ADDR_W+log2(AXIL_DATA_W/8)-1 : log2(AXIL_DATA_W/8)]
- READ_LATENCY, 1, cycles from read_en_o to data_i valid; ≥ 1
- NUM_WORDS, 2**NATIVE_ADDR_W, valid word range [0, NUM_WORDS-1]; used only with VGA_AXIL_SLVERR_EN
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- awaddr  in  AXIL_ADDR_W  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  AXIL_DATA_W  write data
- wstrb  in  AXIL_DATA_W/8  write byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  AXIL_ADDR_W  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  AXIL_DATA_W  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- write_en_o  out  1  native write strobe, one-cycle pulse
- addr_write_o  out  NATIVE_ADDR_W  native write word address
- data_o  out  AXIL_DATA_W  native write data
- strb_o  out  AXIL_DATA_W/8  native write byte enables (copy of wstrb)
- read_en_o  out  1  native read strobe, one-cycle pulse
- addr_read_o  out  NATIVE_ADDR_W  native read word address
- data_i  in  AXIL_DATA_W  native read data, valid READ_LATENCY cycles after read_en_o
## Operation
- Write FSM: W_IDLE, W_HAVE_AW, W_HAVE_W, W_EXEC, W_RESP. W_IDLE: AW and W handshake together → W_EXEC; AW only → W_HAVE_AW (capture addr); W only → W_HAVE_W (capture data/strb). W_HAVE_AW: W handshake → W_EXEC. W_HAVE_W: AW handshake → W_EXEC. W_EXEC → W_RESP unconditionally. W_RESP: bvalid=1; bready → W_IDLE.
- awready=1 only when next write state ∈ {W_IDLE, W_HAVE_W}; wready=1 only when next state ∈ {W_IDLE, W_HAVE_AW}. Both are registered.
- write_en_o=1 exactly during W_EXEC. addr_write_o, data_o, and strb_o hold the captured values from the capture cycle until the next capture.
- Read FSM: R_IDLE, R_ISSUE, R_WAIT, R_RESP. R_IDLE: AR handshake → R_ISSUE (capture addr). R_ISSUE: read_en_o=1, load down-counter with READ_LATENCY-1 → R_WAIT. R_WAIT: at count 0 register data_i into rdata → R_RESP; otherwise decrement. R_RESP: rvalid=1; rready → R_IDLE.
- arready is registered and equals 1 only when next read state is R_IDLE.
- rdata and bresp/rresp are stable while valid is high. Response is OKAY (2'b00) unless SLVERR is flagged.
- Read and write FSMs never block each other. A same-cycle native read and write to the same address has its ordering defined by the native side.
## Timing
- Reset: all FSMs in IDLE. Every output is 0, including awready, wready, and arready; addr/data/strb/rdata registers are 0. Readies rise in the first cycle after rst falls.
- rst asserted mid-transaction aborts the transaction in the next cycle, with no native strobe and no response.
- Write latency: handshake completes in cycle T → write_en_o in T+1 → bvalid from T+2. Minimum 3 cycles per write with bready held high.
- Read latency: AR handshake in T → read_en_o in T+1 → data_i sampled in T+1+READ_LATENCY → rvalid from T+2+READ_LATENCY. bvalid and rvalid stay high until their ready is seen.
## Configuration
- VGA_AXIL_SLVERR_EN defined: a captured word address ≥ NUM_WORDS suppresses write_en_o/read_en_o and returns SLVERR (2'b10) with rdata=0. FSM timing is unchanged.
- Undefined: no range check; the address is truncated to NATIVE_ADDR_W; the response is always OKAY.
## Test plan
- Write: AW 0x0000_0010 and W 0xDEAD_BEEF/strb 4'hF in the same cycle, bready=1 → write_en_o one cycle later with addr_write_o=4 and data_o=0xDEAD_BEEF; bvalid next cycle with bresp=0.
- Write: W (0x1234_5678, strb 4'h3) 3 cycles before AW 0x8 → single write_en_o after the AW handshake with addr 2 and strb_o=4'h3; awready low while in W_HAVE_AW, wready low while in W_HAVE_W.
- READ_LATENCY=3, AR 0x4, data_i=0xCAFE_0001 presented 3 cycles after read_en_o → rvalid 5 cycles after the handshake with rdata=0xCAFE_0001. rready held low for 4 cycles → rvalid/rdata stable, arready=0.
- Concurrent read and write issued in the same cycle → both native strobes fire and both responses return, with no added latency on either.
- With VGA_AXIL_SLVERR_EN, NUM_WORDS=16, write and read to word 20 → no native strobes; bresp=rresp=2'b10, rdata=0. rst pulsed during R_WAIT → rvalid never rises, arready=1 after release.
